// File: rtl/vga_text_scan.sv
// 80x60 text-buffer scanner for 640x480@60 Hz VGA, with an external 8x8 font ROM.
// The buffer is written through a col/row port; the scan pipeline is counters -> RAM -> ROM -> pixel.
module vga_text_scan #(
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  col,
  input  logic [7:0]  row,
  input  logic [7:0]  vga_data,
  input  logic        GPIO_VGA_WE,
  output logic [9:0]  font_addr,
  input  logic [7:0]  font_data,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd752;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd492;
  localparam logic [9:0] V_LAST   = 10'd524;

  // S0: scan counters
  logic [9:0] h_cnt, v_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  logic vis0, hs0, vs0, fs0;
  assign vis0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs0  = !((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E));
  assign vs0  = !((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E));
  assign fs0  = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // Character buffer: not touched by rst, comes up as all spaces.
  logic [7:0]  mem [0:4799] = '{default: 8'h20};
  logic [12:0] wr_addr, rd_addr;
  logic        wr_ok;

  assign wr_ok   = (col < 8'd80) && (row < 8'd60);
  assign wr_addr = 13'(row) * 13'd80 + 13'(col);
  assign rd_addr = 13'(v_cnt[9:3]) * 13'd80 + 13'(h_cnt[9:3]);

  always_ff @(posedge clk) begin
    if (GPIO_VGA_WE && wr_ok)
      mem[wr_addr] <= vga_data;
  end

  // S1..S3 pipeline; sideband signals are delayed to stay aligned with the pixel.
  logic [7:0] code;
  logic [2:0] vlow1, hlow1, hlow2, hlow3;
  logic       vis1, vis2, vis3;
  logic       hs1, hs2, vs1, vs2, fs1, fs2;
  logic       inv2, inv3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code        <= '0;
      vlow1       <= '0;
      hlow1       <= '0;
      hlow2       <= '0;
      hlow3       <= '0;
      vis1        <= 1'b0;
      vis2        <= 1'b0;
      vis3        <= 1'b0;
      hs1         <= 1'b1;
      hs2         <= 1'b1;
      hsync       <= 1'b1;
      vs1         <= 1'b1;
      vs2         <= 1'b1;
      vsync       <= 1'b1;
      fs1         <= 1'b0;
      fs2         <= 1'b0;
      frame_start <= 1'b0;
      font_addr   <= '0;
      inv2        <= 1'b0;
      inv3        <= 1'b0;
    end else begin
      // A write to the cell being read this cycle lands after the read (old data wins).
      code        <= vis0 ? mem[rd_addr] : 8'h00;
      vlow1       <= v_cnt[2:0];
      hlow1       <= h_cnt[2:0];
      vis1        <= vis0;
      hs1         <= hs0;
      vs1         <= vs0;
      fs1         <= fs0;

      font_addr   <= {code[6:0], vlow1};
      inv2        <= code[7];
      hlow2       <= hlow1;
      vis2        <= vis1;
      hs2         <= hs1;
      vs2         <= vs1;
      fs2         <= fs1;

      inv3        <= inv2;
      hlow3       <= hlow2;
      vis3        <= vis2;
      hsync       <= hs2;
      vsync       <= vs2;
      frame_start <= fs2;
    end
  end

  // S3: font ROM output is the stage register; pick the bit and colour it.
  logic pixel;
  assign pixel = font_data[3'd7 - hlow3] ^ inv3;
  assign rgb   = vis3 ? (pixel ? FG_COLOR : BG_COLOR) : 12'h000;

endmodule

// File: tb/tb_vga_text_scan.sv
// Directed bench for vga_text_scan: reset values, glyph rendering, inverse video,
// dropped out-of-range writes, same-cell collision, sync timing and mid-frame reset.
module tb_vga_text_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  col, row, vga_data;
  logic        GPIO_VGA_WE;
  logic [9:0]  font_addr;
  logic [7:0]  font_data = 8'h00;
  logic        hsync, vsync, frame_start;
  logic [11:0] rgb;

  int cyc;
  int total  = 0;
  int passes = 0;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  vga_text_scan #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (
    .clk        (clk),
    .rst        (rst),
    .col        (col),
    .row        (row),
    .vga_data   (vga_data),
    .GPIO_VGA_WE(GPIO_VGA_WE),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  // Font contents used by the bench.
  function automatic logic [7:0] rom(input logic [6:0] c, input logic [2:0] l);
    if (c == 7'h41)
      return (l == 3'd0) ? 8'h81 : (8'h42 ^ {5'd0, l});
    else if (c == 7'h58)
      return 8'hFF;
    else
      return 8'h00;
  endfunction

  function automatic logic [11:0] exp_rgb(input logic [7:0] c, input logic [2:0] l,
                                          input logic [2:0] xx);
    logic [7:0] g;
    logic       px;
    g  = rom(c[6:0], l);
    px = g[3'd7 - xx] ^ c[7];
    return px ? FG : BG;
  endfunction

  // Synchronous font ROM: one-cycle read latency.
  always @(posedge clk) font_data <= rom(font_addr[9:3], font_addr[2:0]);

  // Cycles since reset release; counters hold (cyc%800, cyc/800) during cycle cyc.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] c, input logic [7:0] r, input logic [7:0] d);
    @(negedge clk);
    col = c; row = r; vga_data = d; GPIO_VGA_WE = 1'b1;
    @(negedge clk);
    GPIO_VGA_WE = 1'b0;
  endtask

  initial begin
    int lows;
    int first_low;
    rst = 1'b1; col = '0; row = '0; vga_data = '0; GPIO_VGA_WE = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_font_addr", 32'(font_addr), 32'd0);

    rst = 1'b0;
    wr(8'd0, 8'd0, 8'h41);
    wr(8'd5, 8'd2, 8'hC1);
    wr(8'd0, 8'd1, 8'h41);
    wr(8'd80, 8'd0, 8'h58);
    wr(8'd0, 8'd60, 8'h58);

    // Restart the scan so the frame below sees the buffer contents from its first pixel.
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wait_cyc(2);
    check("fs_before", 32'(frame_start), 32'd0);
    wait_cyc(3);
    check("fs_pulse", 32'(frame_start), 32'd1);
    check("glyph_l0_x0", 32'(rgb), 32'(FG));
    for (int x = 1; x < 8; x++) begin
      wait_cyc(x + 3);
      if (x == 1) check("fs_after", 32'(frame_start), 32'd0);
      check($sformatf("glyph_l0_x%0d", x), 32'(rgb), 32'(exp_rgb(8'h41, 3'd0, 3'(x))));
    end

    // Collision: write cell (3,0) in the cycle S1 reads it at h=24 on line 0.
    wait_cyc(24);
    col = 8'd3; row = 8'd0; vga_data = 8'h58; GPIO_VGA_WE = 1'b1;
    wait_cyc(25);
    GPIO_VGA_WE = 1'b0;
    wait_cyc(27);
    check("collision_old", 32'(rgb), 32'(BG));

    lows = 0;
    first_low = -1;
    for (int c = 650; c <= 770; c++) begin
      wait_cyc(c);
      if (!hsync) begin
        lows++;
        if (first_low < 0) first_low = c;
      end
    end
    check("hsync_first_low", 32'(first_low), 32'd659);
    check("hsync_low_width", 32'(lows), 32'd96);

    wait_cyc(803);
    check("fs_line1_none", 32'(frame_start), 32'd0);
    wait_cyc(827);
    check("collision_new_line1", 32'(rgb), 32'(FG));
    wait_cyc(1458);
    check("hsync_l1_before", 32'(hsync), 32'd1);
    wait_cyc(1459);
    check("hsync_l1_period", 32'(hsync), 32'd0);

    // Out-of-range writes must not have disturbed cell (0,1).
    for (int x = 0; x < 8; x++) begin
      wait_cyc(8 * 800 + x + 3);
      check($sformatf("oor_cell01_x%0d", x), 32'(rgb), 32'(exp_rgb(8'h41, 3'd0, 3'(x))));
    end

    wait_cyc(12000);
    check("vsync_visible", 32'(vsync), 32'd1);

    for (int l = 16; l < 24; l++) begin
      for (int x = 40; x < 48; x++) begin
        if (l < 23 || x < 44) begin
          wait_cyc(l * 800 + x + 3);
          check($sformatf("inverse_l%0d_x%0d", l, x), 32'(rgb),
                32'(exp_rgb(8'hC1, 3'(l - 16), 3'(x - 40))));
        end
      end
    end

    // Mid-frame reset while an inverse foreground pixel is on the output.
    wait_cyc(23 * 800 + 47);
    check("pre_reset_rgb", 32'(rgb), 32'(exp_rgb(8'hC1, 3'd7, 3'd4)));
    rst = 1'b1;
    #1;
    check("midrst_rgb", 32'(rgb), 32'd0);
    check("midrst_hsync", 32'(hsync), 32'd1);
    check("midrst_vsync", 32'(vsync), 32'd1);
    check("midrst_fs", 32'(frame_start), 32'd0);
    check("midrst_font_addr", 32'(font_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wait_cyc(2);
    check("post_rst_fs_before", 32'(frame_start), 32'd0);
    wait_cyc(3);
    check("post_rst_fs_pulse", 32'(frame_start), 32'd1);
    check("post_rst_glyph_x0", 32'(rgb), 32'(FG));
    wait_cyc(4);
    check("post_rst_glyph_x1", 32'(rgb), 32'(BG));
    wait_cyc(27);
    check("post_rst_collision_new", 32'(rgb), 32'(FG));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
